// File: rtl/uart_mmio_pkg.sv
// uart_mmio_pkg
//   Shared definitions for the uart MMIO controller: register word offsets,
//   STATUS bit positions and the TX/RX sequencer state encodings.
package uart_mmio_pkg;

  // Register word offsets (address[3:2])
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // STATUS register bit indices
  localparam int ST_TX_FULL   = 0;
  localparam int ST_TX_EMPTY  = 1;
  localparam int ST_RX_NEMPTY = 2;
  localparam int ST_RX_FULL   = 3;
  localparam int ST_TX_ACTIVE = 4;
  localparam int ST_TX_OVF    = 5;
  localparam int ST_RX_OVR    = 6;

  // CTRL register bit indices
  localparam int CTRL_CLR_TX_OVF = 0;
  localparam int CTRL_CLR_RX_OVR = 1;
  localparam int CTRL_RX_IRQ_EN  = 2;

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} tx_state_t;
  typedef enum logic {RX_IDLE, RX_CLR} rx_state_t;

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// uart_mmio_ctrl_if
//   Bundles the CPU register-window bus and the uart-side handshake of the
//   uart MMIO controller.
//   CPU side : sel, memWrite, memRead, address, WriteData -> ReadData
//   uart side: tx_data, wr_en -> uart; Tx_busy, rx_ready, rx_data <- uart;
//              ready_clr -> uart; irq -> core
//   slave  modport: used by the controller
//   master modport: used by whatever drives the controller (core + uart)
interface uart_mmio_ctrl_if #(
  parameter int Width = 32
);
  logic             sel;
  logic             memWrite;
  logic             memRead;
  logic [1:0]       address;
  logic [Width-1:0] WriteData;
  logic [Width-1:0] ReadData;
  logic [7:0]       tx_data;
  logic             wr_en;
  logic             Tx_busy;
  logic             rx_ready;
  logic [7:0]       rx_data;
  logic             ready_clr;
  logic             irq;

  modport slave (
    input  sel, memWrite, memRead, address, WriteData, Tx_busy, rx_ready, rx_data,
    output ReadData, tx_data, wr_en, ready_clr, irq
  );

  modport master (
    output sel, memWrite, memRead, address, WriteData, Tx_busy, rx_ready, rx_data,
    input  ReadData, tx_data, wr_en, ready_clr, irq
  );
endinterface

// File: rtl/uart_mmio_ctrl_sync_fifo.sv
// sync_fifo
//   Single-clock FIFO with combinational head output.
//   push/pop : write/read strobes; a push while full is accepted only when a
//              pop happens in the same cycle, a pop while empty is ignored
//   din/dout : data in / head of queue
//   full, empty, count : occupancy
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop frees a slot in the same cycle, so a push on full is accepted then
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl
//   Memory-mapped controller between the core's IO bus and the uart.
//   Buffers transmit bytes in a TX FIFO and feeds them to the uart one at a
//   time (wr_en / Tx_busy handshake), drains received bytes (ready /
//   ready_clr) into an RX FIFO and exposes TXDATA/RXDATA/STATUS/CTRL.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : uart_mmio_ctrl_if.slave (CPU register window + uart signals)
module uart_mmio_ctrl
  import uart_mmio_pkg::*;
#(
  parameter int Width        = 32,
  parameter int TX_DEPTH     = 8,
  parameter int RX_DEPTH     = 8,
  parameter int BUSY_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst_n,
  uart_mmio_ctrl_if.slave  bus
);
  localparam int TW = $clog2(BUSY_TIMEOUT) + 1;

  tx_state_t tx_state, tx_next;
  rx_state_t rx_state, rx_next;

  logic [TW-1:0] to_cnt;
  logic [7:0]    tx_data_q;
  logic          ready_clr_q;
  logic          tx_ovf, rx_ovr, rx_irq_en;
  logic          wr_en_c;

  logic bus_wr, bus_rd, ctrl_wr;
  logic tx_push, tx_pop, rx_push, rx_pop;

  logic [7:0]                  tx_dout, rx_dout;
  logic                        tx_full, tx_empty, rx_full, rx_empty;
  logic [$clog2(TX_DEPTH):0]   tx_count;
  logic [$clog2(RX_DEPTH):0]   rx_count;
  logic [6:0]                  status;
  logic [Width-1:0]            read_data;
  logic                        unused_bits;

  assign bus_wr  = bus.sel & bus.memWrite;
  assign bus_rd  = bus.sel & bus.memRead;
  assign tx_push = bus_wr & (bus.address == REG_TXDATA);
  assign ctrl_wr = bus_wr & (bus.address == REG_CTRL);
  assign rx_pop  = bus_rd & (bus.address == REG_RXDATA);

  assign unused_bits = ^{bus.WriteData[Width-1:8], tx_count, rx_count};

  sync_fifo #(.DW(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(rst_n), .push(tx_push), .pop(tx_pop),
    .din(bus.WriteData[7:0]), .dout(tx_dout),
    .full(tx_full), .empty(tx_empty), .count(tx_count)
  );

  sync_fifo #(.DW(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(rst_n), .push(rx_push), .pop(rx_pop),
    .din(bus.rx_data), .dout(rx_dout),
    .full(rx_full), .empty(rx_empty), .count(rx_count)
  );

  // TX sequencer: state, busy-timeout counter and the held transmit byte
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state  <= IDLE;
      to_cnt    <= '0;
      tx_data_q <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_pop) tx_data_q <= tx_dout;
      if (tx_state == LOAD)           to_cnt <= '0;
      else if (tx_state == WAIT_BUSY) to_cnt <= to_cnt + TW'(1);
    end
  end

  // IDLE also waits for Tx_busy low so a uart still busy after our reset
  // is never handed a new byte. A timeout in WAIT_BUSY drops the byte.
  always_comb begin
    tx_next = tx_state;
    tx_pop  = 1'b0;
    wr_en_c = 1'b0;
    unique case (tx_state)
      IDLE: begin
        if (!tx_empty && !bus.Tx_busy) begin
          tx_pop  = 1'b1;
          tx_next = LOAD;
        end
      end
      LOAD: begin
        wr_en_c = 1'b1;
        tx_next = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (bus.Tx_busy)                        tx_next = WAIT_DONE;
        else if (to_cnt == TW'(BUSY_TIMEOUT-1)) tx_next = IDLE;
      end
      WAIT_DONE: begin
        if (!bus.Tx_busy) tx_next = IDLE;
      end
      default: tx_next = IDLE;
    endcase
  end

  // RX capture: ready_clr is registered so it is a clean one-cycle pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state    <= RX_IDLE;
      ready_clr_q <= 1'b0;
    end else begin
      rx_state    <= rx_next;
      ready_clr_q <= rx_push;
    end
  end

  // RX_CLR waits for ready to drop, so a held ready is captured only once
  always_comb begin
    rx_next = rx_state;
    rx_push = 1'b0;
    unique case (rx_state)
      RX_IDLE: begin
        if (bus.rx_ready) begin
          rx_push = 1'b1;
          rx_next = RX_CLR;
        end
      end
      RX_CLR: begin
        if (!bus.rx_ready) rx_next = RX_IDLE;
      end
      default: rx_next = RX_IDLE;
    endcase
  end

  // Sticky flags: a set in the same cycle as its clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ovf    <= 1'b0;
      rx_ovr    <= 1'b0;
      rx_irq_en <= 1'b0;
    end else begin
      if (tx_push && tx_full && !tx_pop)                  tx_ovf <= 1'b1;
      else if (ctrl_wr && bus.WriteData[CTRL_CLR_TX_OVF]) tx_ovf <= 1'b0;
      if (rx_push && rx_full && !rx_pop)                  rx_ovr <= 1'b1;
      else if (ctrl_wr && bus.WriteData[CTRL_CLR_RX_OVR]) rx_ovr <= 1'b0;
      if (ctrl_wr) rx_irq_en <= bus.WriteData[CTRL_RX_IRQ_EN];
    end
  end

  always_comb begin
    status               = '0;
    status[ST_TX_FULL]   = tx_full;
    status[ST_TX_EMPTY]  = tx_empty;
    status[ST_RX_NEMPTY] = ~rx_empty;
    status[ST_RX_FULL]   = rx_full;
    status[ST_TX_ACTIVE] = (tx_state != IDLE);
    status[ST_TX_OVF]    = tx_ovf;
    status[ST_RX_OVR]    = rx_ovr;
  end

  // Register read mux; an empty RX FIFO reads 0 rather than a stale entry
  always_comb begin
    read_data = '0;
    case (bus.address)
      REG_RXDATA: if (!rx_empty) read_data[7:0] = rx_dout;
      REG_STATUS: read_data[6:0] = status;
      REG_CTRL:   read_data[CTRL_RX_IRQ_EN] = rx_irq_en;
      default:    read_data = '0;
    endcase
  end

  assign bus.ReadData  = read_data;
  assign bus.tx_data   = tx_data_q;
  assign bus.wr_en     = wr_en_c;
  assign bus.ready_clr = ready_clr_q;
  assign bus.irq       = rx_irq_en & ~rx_empty;
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// tb_uart_mmio_ctrl
//   Bench for uart_mmio_ctrl: a small uart model answers wr_en with Tx_busy,
//   transmitted and received bytes are tracked in scoreboard queues.
module tb_uart_mmio_ctrl;
  import uart_mmio_pkg::*;

  localparam int BUSY_NORMAL = 0;
  localparam int BUSY_HOLD   = 1;
  localparam int BUSY_NEVER  = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  uart_mmio_ctrl_if #(.Width(32)) bus ();

  uart_mmio_ctrl #(
    .Width(32), .TX_DEPTH(8), .RX_DEPTH(8), .BUSY_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int vec_count  = 0;
  int miss_count = 0;
  int wr_pulses  = 0;
  int clr_pulses = 0;
  int unexp_wr   = 0;
  int busy_mode  = BUSY_NORMAL;
  logic prev_wr  = 1'b0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.memWrite = 1'b1; bus.address = a; bus.WriteData = d;
    @(negedge clk);
    bus.sel = 1'b0; bus.memWrite = 1'b0; bus.WriteData = '0;
  endtask

  task automatic popRead(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.sel = 1'b1; bus.memRead = 1'b1; bus.address = a;
    #1 d = bus.ReadData;
    @(negedge clk);
    bus.sel = 1'b0; bus.memRead = 1'b0;
  endtask

  task automatic peekReg(input logic [1:0] a, output logic [31:0] d);
    bus.address = a;
    #1 d = bus.ReadData;
  endtask

  task automatic sendRx(input logic [7:0] b);
    @(negedge clk); bus.rx_data = b; bus.rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); bus.rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic waitTxIdle(input int budget, input string tag);
    logic [31:0] st;
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      peekReg(REG_STATUS, st);
      if (!st[ST_TX_ACTIVE] && st[ST_TX_EMPTY] && tx_q.size() == 0) done = 1'b1;
    end
    checkOutput(tag, {31'b0, done}, 32'd1);
  endtask

  // uart model: Tx_busy rises two cycles after wr_en and lasts 10 cycles
  initial begin : uart_model
    bus.Tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.wr_en && busy_mode != BUSY_NEVER) begin
        @(negedge clk);
        @(negedge clk);
        bus.Tx_busy = 1'b1;
        repeat (10) @(negedge clk);
        while (busy_mode == BUSY_HOLD) @(negedge clk);
        bus.Tx_busy = 1'b0;
      end
    end
  end

  // Transmit monitor: each wr_en must carry the next queued byte and be one cycle wide
  always @(negedge clk) begin
    if (prev_wr) checkOutput("wr_en_width", {31'b0, bus.wr_en}, 32'd0);
    if (bus.wr_en) begin
      wr_pulses++;
      if (tx_q.size() > 0) checkOutput("tx_data", {24'b0, bus.tx_data}, {24'b0, tx_q.pop_front()});
      else unexp_wr++;
    end
    if (bus.ready_clr) clr_pulses++;
    prev_wr = bus.wr_en;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    logic [31:0] d;
    int base_wr, base_clr, active_cycles;

    rst_n = 1'b0;
    bus.sel = 1'b0; bus.memWrite = 1'b0; bus.memRead = 1'b0;
    bus.address = REG_TXDATA; bus.WriteData = '0;
    bus.rx_ready = 1'b0; bus.rx_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    checkOutput("rst_wr_en", {31'b0, bus.wr_en}, 32'd0);
    checkOutput("rst_ready_clr", {31'b0, bus.ready_clr}, 32'd0);
    checkOutput("rst_irq", {31'b0, bus.irq}, 32'd0);
    checkOutput("rst_tx_data", {24'b0, bus.tx_data}, 32'd0);
    peekReg(REG_STATUS, d);
    checkOutput("rst_status", d, 32'h02);
    peekReg(REG_CTRL, d);
    checkOutput("rst_ctrl", d, 32'h0);

    // 1: two bytes through the normal handshake
    base_wr = wr_pulses;
    tx_q.push_back(8'h41); applyStimulus(REG_TXDATA, 32'h41);
    tx_q.push_back(8'h42); applyStimulus(REG_TXDATA, 32'h42);
    waitTxIdle(200, "t1_drain");
    checkOutput("t1_wr_pulses", wr_pulses - base_wr, 32'd2);
    peekReg(REG_STATUS, d);
    checkOutput("t1_status", d, 32'h02);

    // 2: fill TX while the uart stays busy, then overflow and clear
    busy_mode = BUSY_HOLD;
    base_wr = wr_pulses;
    tx_q.push_back(8'h00); applyStimulus(REG_TXDATA, 32'h00);
    repeat (6) @(negedge clk);
    for (int i = 1; i <= 8; i++) begin
      tx_q.push_back(8'(i));
      applyStimulus(REG_TXDATA, 32'(i));
    end
    checkOutput("t2_tx_data_held", {24'b0, bus.tx_data}, 32'h00);
    peekReg(REG_STATUS, d);
    checkOutput("t2_status_full", d, 32'h11);
    applyStimulus(REG_TXDATA, 32'h09);
    peekReg(REG_STATUS, d);
    checkOutput("t2_status_ovf", d, 32'h31);
    applyStimulus(REG_CTRL, 32'h1);
    peekReg(REG_STATUS, d);
    checkOutput("t2_status_ovf_clr", d, 32'h11);
    busy_mode = BUSY_NORMAL;
    waitTxIdle(400, "t2_drain");
    checkOutput("t2_wr_pulses", wr_pulses - base_wr, 32'd9);

    // 3: a held rx_ready captures exactly one byte
    base_clr = clr_pulses;
    @(negedge clk); bus.rx_data = 8'h5A; bus.rx_ready = 1'b1;
    rx_q.push_back(8'h5A);
    repeat (5) @(negedge clk);
    bus.rx_ready = 1'b0;
    @(negedge clk);
    checkOutput("t3_clr_pulses", clr_pulses - base_clr, 32'd1);
    peekReg(REG_STATUS, d);
    checkOutput("t3_status_nempty", d, 32'h06);
    popRead(REG_RXDATA, d);
    checkOutput("t3_rxdata", d, {24'b0, rx_q.pop_front()});
    peekReg(REG_STATUS, d);
    checkOutput("t3_status_empty", d, 32'h02);

    // 4: fill RX, overflow, then simultaneous push and pop while full
    base_clr = clr_pulses;
    for (int i = 0; i < 8; i++) begin
      rx_q.push_back(8'h10 + 8'(i));
      sendRx(8'h10 + 8'(i));
    end
    sendRx(8'hFF);
    checkOutput("t4_clr_pulses", clr_pulses - base_clr, 32'd9);
    peekReg(REG_STATUS, d);
    checkOutput("t4_status_ovr", d, 32'h4E);
    peekReg(REG_RXDATA, d);
    checkOutput("t4_head", d, {24'b0, rx_q[0]});
    @(negedge clk);
    bus.rx_data = 8'h20; bus.rx_ready = 1'b1;
    bus.sel = 1'b1; bus.memRead = 1'b1; bus.address = REG_RXDATA;
    #1 d = bus.ReadData;
    checkOutput("t4_simul_head", d, {24'b0, rx_q.pop_front()});
    rx_q.push_back(8'h20);
    @(negedge clk); bus.sel = 1'b0; bus.memRead = 1'b0;
    @(negedge clk); bus.rx_ready = 1'b0;
    @(negedge clk);
    applyStimulus(REG_CTRL, 32'h2);
    peekReg(REG_STATUS, d);
    checkOutput("t4_status_full_kept", d, 32'h0E);

    // 5: busy never rises, FSM gives up after the timeout; then irq
    busy_mode = BUSY_NEVER;
    base_wr = wr_pulses;
    active_cycles = 0;
    tx_q.push_back(8'h77); applyStimulus(REG_TXDATA, 32'h77);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      peekReg(REG_STATUS, d);
      if (d[ST_TX_ACTIVE]) active_cycles++;
      else if (active_cycles > 0) break;
    end
    checkOutput("t5_active_cycles", active_cycles, 32'd17);
    checkOutput("t5_wr_pulses", wr_pulses - base_wr, 32'd1);
    busy_mode = BUSY_NORMAL;
    applyStimulus(REG_CTRL, 32'h4);
    checkOutput("t5_irq_on", {31'b0, bus.irq}, 32'd1);
    peekReg(REG_CTRL, d);
    checkOutput("t5_ctrl", d, 32'h4);
    for (int i = 0; i < 8; i++) begin
      popRead(REG_RXDATA, d);
      checkOutput("t5_rx_drain", d, {24'b0, rx_q.pop_front()});
    end
    checkOutput("t5_irq_off", {31'b0, bus.irq}, 32'd0);
    applyStimulus(REG_CTRL, 32'h0);

    // 6: reset during WAIT_DONE with bytes still queued
    tx_q.push_back(8'hA0); applyStimulus(REG_TXDATA, 32'hA0);
    applyStimulus(REG_TXDATA, 32'hA1);
    applyStimulus(REG_TXDATA, 32'hA2);
    applyStimulus(REG_TXDATA, 32'hA3);
    peekReg(REG_STATUS, d);
    checkOutput("t6_status_pre", d, 32'h10);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_wr_en", {31'b0, bus.wr_en}, 32'd0);
    checkOutput("t6_rst_tx_data", {24'b0, bus.tx_data}, 32'd0);
    checkOutput("t6_rst_ready_clr", {31'b0, bus.ready_clr}, 32'd0);
    peekReg(REG_STATUS, d);
    checkOutput("t6_rst_status", d, 32'h02);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base_wr = wr_pulses;
    repeat (30) @(negedge clk);
    checkOutput("t6_no_wr_after", wr_pulses - base_wr, 32'd0);
    checkOutput("tx_queue_left", tx_q.size(), 32'd0);
    checkOutput("tx_unexpected_wr", unexp_wr, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end
endmodule
